// File: rtl/keypad_scan_ctrl.sv
// ============================================================================
// Module  : keypad_scan_ctrl
// Brief   : 4x4 active-low keypad scanner, per-key frame debounce, sticky flags
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module keypad_scan_ctrl #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int          DEBOUNCE = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  input  logic        key_clear,
  output logic [15:0] key_data,
  output logic [15:0] key_state,
  output logic        key_irq
);

  localparam int                 c_CNT_W  = $clog2(DEBOUNCE + 1);
  localparam logic [c_CNT_W-1:0] c_DB_MAX = c_CNT_W'(DEBOUNCE - 1);
  localparam logic [c_CNT_W-1:0] c_DB_ONE = c_CNT_W'(1);
  localparam logic [15:0]        c_DIV_END = SCAN_DIV - 16'd1;

  typedef enum logic [1:0] {
    ROW0 = 2'd0,
    ROW1 = 2'd1,
    ROW2 = 2'd2,
    ROW3 = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [15:0]         r_div_cnt;
  logic                w_row_end;
  logic [3:0]          r_col_s1;
  logic [3:0]          r_col_s2;
  logic [15:0]         r_sample;
  logic                r_frame_tick;
  logic [c_CNT_W-1:0]  r_cnt [16];
  logic [15:0]         w_flip;
  logic [15:0]         r_key_state;
  logic [15:0]         r_press_edge;
  logic [15:0]         r_key_data;
  logic                r_key_irq;

  assign w_row_end = (r_div_cnt == c_DIV_END);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ROW0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    row_n       = 4'b1110;
    case (r_state)
      ROW0: begin
        row_n = 4'b1110;
        if (w_row_end) w_state_nxt = ROW1;
      end
      ROW1: begin
        row_n = 4'b1101;
        if (w_row_end) w_state_nxt = ROW2;
      end
      ROW2: begin
        row_n = 4'b1011;
        if (w_row_end) w_state_nxt = ROW3;
      end
      ROW3: begin
        row_n = 4'b0111;
        if (w_row_end) w_state_nxt = ROW0;
      end
      default: w_state_nxt = ROW0;
    endcase
  end

  // Row timing, column synchronizer and per-row sample capture
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_div_cnt    <= '0;
      r_col_s1     <= 4'hF;
      r_col_s2     <= 4'hF;
      r_sample     <= '0;
      r_frame_tick <= 1'b0;
    end else begin
      r_col_s1     <= col_n;
      r_col_s2     <= r_col_s1;
      r_frame_tick <= w_row_end && (r_state == ROW3);
      if (w_row_end) begin
        r_div_cnt                       <= '0;
        r_sample[{r_state, 2'b00} +: 4] <= ~r_col_s2;
      end else begin
        r_div_cnt <= r_div_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    w_flip = '0;
    for (int k = 0; k < 16; k++) begin
      w_flip[k] = r_frame_tick && (r_sample[k] != r_key_state[k]) &&
                  (r_cnt[k] == c_DB_MAX);
    end
  end

  // Any agreeing frame restarts the count, so short bounces never flip a key
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int k = 0; k < 16; k++) begin
        r_cnt[k] <= '0;
      end
      r_key_state  <= '0;
      r_press_edge <= '0;
      r_key_data   <= '0;
      r_key_irq    <= 1'b0;
    end else begin
      if (r_frame_tick) begin
        for (int k = 0; k < 16; k++) begin
          if ((r_sample[k] == r_key_state[k]) || w_flip[k]) begin
            r_cnt[k] <= '0;
          end else begin
            r_cnt[k] <= r_cnt[k] + c_DB_ONE;
          end
        end
      end
      r_key_state  <= r_key_state ^ w_flip;
      r_press_edge <= w_flip & ~r_key_state;
      r_key_data   <= key_clear ? r_press_edge : (r_key_data | r_press_edge);
      r_key_irq    <= |r_key_data;
    end
  end

  assign key_state = r_key_state;
  assign key_data  = r_key_data;
  assign key_irq   = r_key_irq;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: stimulus queues expected snapshots and
// key_data transitions; monitors pop and compare.
`default_nettype none

module tb_keypad_scan_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic [3:0]  col_n;
  logic [3:0]  row_n;
  logic        key_clear;
  logic [15:0] key_data;
  logic [15:0] key_state;
  logic        key_irq;

  logic [15:0] pressed;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    bit          chk_row;
    logic [3:0]  row;
    logic [15:0] st;
    logic [15:0] dat;
    logic        irq;
  } snap_t;

  snap_t       snap_q[$];
  logic [15:0] data_q[$];
  event        snap_ev;
  bit          mon_en = 1'b0;
  logic [15:0] prev_data = '0;

  keypad_scan_ctrl #(
    .SCAN_DIV (16'd4),
    .DEBOUNCE (3)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .col_n     (col_n),
    .row_n     (row_n),
    .key_clear (key_clear),
    .key_data  (key_data),
    .key_state (key_state),
    .key_irq   (key_irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Keypad model: a held key pulls its column low while its row is driven
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (row_n[r] == 1'b0) begin
        for (int c = 0; c < 4; c++) begin
          if (pressed[r*4+c]) col_n[c] = 1'b0;
        end
      end
    end
  end

  task automatic cmp(input string nm, input string fld, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", nm, fld, got, exp);
    end
  endtask

  // Snapshot monitor
  initial begin
    snap_t s;
    forever begin
      @(snap_ev);
      while (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        if (s.chk_row) cmp(s.name, "row_n", {12'h0, row_n}, {12'h0, s.row});
        cmp(s.name, "key_state", key_state, s.st);
        cmp(s.name, "key_data", key_data, s.dat);
        cmp(s.name, "key_irq", {15'h0, key_irq}, {15'h0, s.irq});
      end
    end
  end

  // key_data transition monitor
  always @(negedge HCLK) begin
    if (mon_en && (key_data !== prev_data)) begin
      if (data_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL key_data_change: got %h, no change expected", key_data);
      end else begin
        cmp("key_data_change", "key_data", key_data, data_q.pop_front());
      end
    end
    prev_data = key_data;
  end

  task automatic snap(input string nm, input logic [15:0] st, input logic [15:0] dat,
                      input logic irq, input bit chk_row, input logic [3:0] row);
    snap_t s;
    s.name = nm; s.chk_row = chk_row; s.row = row;
    s.st = st;   s.dat = dat;         s.irq = irq;
    snap_q.push_back(s);
    -> snap_ev;
    #1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Returns at the negedge just after the row-3 -> row-0 wrap (frame_tick cycle)
  task automatic frames(input int n);
    logic [3:0] p;
    bit ok;
    for (int f = 0; f < n; f++) begin
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        p = row_n;
        @(negedge HCLK);
        if (p == 4'b0111 && row_n == 4'b1110) ok = 1'b1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL frame_wait: got no row wrap in 40 cycles, expected one");
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] er;
    HRESETn   = 1'b0;
    key_clear = 1'b0;
    pressed   = '0;
    cycles(3);
    HRESETn   = 1'b1;
    prev_data = key_data;
    mon_en    = 1'b1;

    // 1: row rotation after reset, outputs idle
    for (int i = 0; i < 16; i++) begin
      er = ~(4'b0001 << ((i / 4) % 4));
      snap("reset_scan", 16'h0, 16'h0, 1'b0, 1'b1, er);
      @(negedge HCLK);
    end

    // 2: hold key 5
    pressed[5] = 1'b1;
    data_q.push_back(16'h0020);
    frames(3);
    snap("press_pre_flip", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);
    cycles(1);
    snap("press_flip", 16'h0020, 16'h0000, 1'b0, 1'b0, 4'h0);
    cycles(1);
    snap("press_data", 16'h0020, 16'h0020, 1'b0, 1'b0, 4'h0);
    cycles(1);
    snap("press_irq", 16'h0020, 16'h0020, 1'b1, 1'b0, 4'h0);
    frames(1);
    snap("press_hold4", 16'h0020, 16'h0020, 1'b1, 1'b0, 4'h0);

    // 4: clear while held, no re-flag, release then re-press
    key_clear = 1'b1;
    data_q.push_back(16'h0000);
    cycles(1);
    key_clear = 1'b0;
    snap("clear_data", 16'h0020, 16'h0000, 1'b1, 1'b0, 4'h0);
    cycles(1);
    snap("clear_irq", 16'h0020, 16'h0000, 1'b0, 1'b0, 4'h0);
    frames(2);
    snap("held_no_reflag", 16'h0020, 16'h0000, 1'b0, 1'b0, 4'h0);
    pressed[5] = 1'b0;
    frames(3);
    cycles(1);
    snap("release", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);
    pressed[5] = 1'b1;
    data_q.push_back(16'h0020);
    frames(3);
    cycles(2);
    snap("repress_data", 16'h0020, 16'h0020, 1'b0, 1'b0, 4'h0);
    cycles(1);
    snap("repress_irq", 16'h0020, 16'h0020, 1'b1, 1'b0, 4'h0);
    frames(1);
    pressed[5] = 1'b0;
    frames(3);
    cycles(1);
    snap("release_keeps_flag", 16'h0000, 16'h0020, 1'b1, 1'b0, 4'h0);
    key_clear = 1'b1;
    data_q.push_back(16'h0000);
    cycles(1);
    key_clear = 1'b0;
    cycles(1);
    snap("clear_idle", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);
    frames(1);

    // 3: bounce 2 on, 1 off, 2 on, off
    pressed[5] = 1'b1; frames(2);
    pressed[5] = 1'b0; frames(1);
    pressed[5] = 1'b1; frames(2);
    pressed[5] = 1'b0; frames(3);
    cycles(2);
    snap("bounce", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);

    // 5: clear coincident with key 10 press edge
    frames(1);
    pressed[5] = 1'b1;
    data_q.push_back(16'h0020);
    frames(3);
    cycles(2);
    snap("k5_again", 16'h0020, 16'h0020, 1'b0, 1'b0, 4'h0);
    frames(1);
    pressed[10] = 1'b1;
    data_q.push_back(16'h0400);
    frames(3);
    cycles(1);
    snap("k10_edge", 16'h0420, 16'h0020, 1'b1, 1'b0, 4'h0);
    key_clear = 1'b1;
    cycles(1);
    key_clear = 1'b0;
    snap("clear_with_edge", 16'h0420, 16'h0400, 1'b1, 1'b0, 4'h0);

    // 6: reset in the middle of a debounce run
    frames(1);
    pressed = 16'h8000;
    frames(2);
    cycles(2);
    data_q.push_back(16'h0000);
    HRESETn = 1'b0;
    #1;
    snap("async_reset", 16'h0000, 16'h0000, 1'b0, 1'b1, 4'b1110);
    cycles(2);
    HRESETn = 1'b1;
    data_q.push_back(16'h8000);
    frames(2);
    cycles(2);
    snap("post_reset_2fr", 16'h0000, 16'h0000, 1'b0, 1'b0, 4'h0);
    frames(1);
    cycles(1);
    snap("post_reset_flip", 16'h8000, 16'h0000, 1'b0, 1'b0, 4'h0);
    cycles(1);
    snap("post_reset_data", 16'h8000, 16'h8000, 1'b0, 1'b0, 4'h0);
    cycles(1);
    snap("post_reset_irq", 16'h8000, 16'h8000, 1'b1, 1'b0, 4'h0);

    cycles(4);
    cmp("drain", "data_q_left", 16'(data_q.size()), 16'h0);
    cmp("drain", "snap_q_left", 16'(snap_q.size()), 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
